// File: rtl/register_file.sv
// MIPS architectural register file: two combinational read ports, one clocked write port,
// hard-wired zero register and an unbypassed debug port. Optional write-through: REGFILE_BYPASS_EN.
module register_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic [ADDR_W-1:0] dbg_ra,
  output logic [WIDTH-1:0]  dbg_rd
);

  localparam int NREG = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [NREG];
  logic             wr_ok;

  assign wr_ok = we && (wa != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // Address 0 is forced to zero on every port, independent of storage contents.
  always_comb begin
    rd1    = (ra1 == '0) ? '0 : regs[ra1];
    rd2    = (ra2 == '0) ? '0 : regs[ra2];
    dbg_rd = (dbg_ra == '0) ? '0 : regs[dbg_ra];
`ifdef REGFILE_BYPASS_EN
    if (reset_n && wr_ok && (ra1 == wa)) rd1 = wd;
    if (reset_n && wr_ok && (ra2 == wa)) rd2 = wd;
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file; expectations adapt to REGFILE_BYPASS_EN.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [4:0]  dbg_ra;
  logic [31:0] dbg_rd;

  int checks = 0;
  int errors = 0;

  register_file #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbg_ra;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    // Each vector is driven after a falling edge and checked before the following rising edge.
    vecs[0]  = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd8,  5'd8,
                 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd8,  5'd0,  32'h0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 5'd9,  32'hAAAA5555, 5'd8,  5'd9,  5'd9,
                 32'hDEADBEEF, (BYP ? 32'hAAAA5555 : 32'h0), 32'h0};
    vecs[5]  = '{1'b0, 5'd9,  32'h0F0F0F0F, 5'd9,  5'd9,  5'd9,
                 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555};
    vecs[6]  = '{1'b0, 5'd9,  32'h0F0F0F0F, 5'd9,  5'd9,  5'd9,
                 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555};
    vecs[7]  = '{1'b1, 5'd9,  32'h0F0F0F0F, 5'd9,  5'd8,  5'd9,
                 (BYP ? 32'h0F0F0F0F : 32'hAAAA5555), 32'hDEADBEEF, 32'hAAAA5555};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  5'd9,
                 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F};
    vecs[9]  = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,  5'd31,
                 (BYP ? 32'hCAFEF00D : 32'h0), 32'h0, 32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31,
                 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};

    reset_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_ra = '0;

    // Reset sweep.
    #2;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a); dbg_ra = 5'(a);
      #1;
      check("reset_rd1", rd1, 32'h0);
      check("reset_rd2", rd2, 32'h0);
      check("reset_dbg", dbg_rd, 32'h0);
    end

    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2; dbg_ra = vecs[i].dbg_ra;
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
      check($sformatf("vec%0d_dbg", i), dbg_rd, vecs[i].ed);
    end

    // Mid-cycle asynchronous reset clears contents before any edge.
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_rd1", rd1, 32'h0);
    check("midrst_rd2", rd2, 32'h0);
    check("midrst_dbg", dbg_rd, 32'h0);
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(a); dbg_ra = 5'(a);
      #1;
      check("midrst_sweep_rd1", rd1, 32'h0);
      check("midrst_sweep_dbg", dbg_rd, 32'h0);
    end

    // Writes during reset are ignored.
    @(negedge clk);
    we = 1'b1; wa = 5'd5; wd = 32'h55555555; ra1 = 5'd5; ra2 = 5'd5; dbg_ra = 5'd5;
    #1;
    check("rst_write_bypass_rd1", rd1, 32'h0);
    @(negedge clk);
    check("rst_write_dbg", dbg_rd, 32'h0);

    // Release and write on the first edge with reset_n high.
    reset_n = 1'b1;
    we = 1'b1; wa = 5'd31; wd = 32'h00000001; ra1 = 5'd0; ra2 = 5'd5; dbg_ra = 5'd31;
    #1;
    check("post_rst_pre_edge_dbg", dbg_rd, 32'h0);
    @(negedge clk);
    we = 1'b0; ra1 = 5'd31; ra2 = 5'd5; dbg_ra = 5'd31;
    #1;
    check("post_rst_rd1", rd1, 32'h00000001);
    check("post_rst_rd2_reg5", rd2, 32'h0);
    check("post_rst_dbg", dbg_rd, 32'h00000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file for the single-cycle MIPS datapath. It sits directly downstream of the write-register-select and write-data-select 2:1 multiplexers, which supply its write address and write data, and upstream of the ALU-source multiplexer, which consumes its second read port. It provides two combinational read ports, one clocked write port, a hard-wired zero register, and a debug read port for testbench inspection.

## Interface
- WIDTH, 32, data width of each register
- ADDR_W, 5, address width; the file holds 2**ADDR_W registers
- clk  input  1  clock; all writes occur on the rising edge
- reset_n  input  1  asynchronous, active-low reset; clears every register
- we  input  1  write enable (RegWrite)
- wa  input  ADDR_W  write address (from the write-register-select mux)
- wd  input  WIDTH  write data (from the write-data-select mux)
- ra1  input  ADDR_W  read address, port 1 (rs)
- ra2  input  ADDR_W  read address, port 2 (rt)
- rd1  output  WIDTH  read data, port 1
- rd2  output  WIDTH  read data, port 2
- dbg_ra  input  ADDR_W  debug read address
- dbg_rd  output  WIDTH  debug read data; never bypassed

## Operation
- Storage: 2**ADDR_W registers of WIDTH bits. Register 0 always reads as 0 and is never written.
- Write: on the rising edge of clk, when reset_n=1, we=1 and wa!=0, reg[wa] takes the value of wd.
  - we=1 with wa=0 is a silent no-op.
  - we=0 leaves all registers unchanged.
- Read: rd1=reg[ra1], rd2=reg[ra2] and dbg_rd=reg[dbg_ra], all purely combinational with no clock involvement.
  - Any read of address 0 returns 0, including when a write to address 0 is attempted.
- Reset: while reset_n=0, every register is 0.
  - rd1, rd2 and dbg_rd therefore read 0 for any address.
  - Writes are ignored.
- Reset mid-operation: assertion clears all contents immediately, without waiting for a clock edge. A write presented on the same edge that reset is asserted is lost.
- Simultaneous events:
  - ra1 and ra2 may be equal; both ports return the same value.
  - A read of wa in the same cycle as a write follows the Configuration rule.
- No handshake and no stall: the file accepts one write per cycle, every cycle.

## Timing
- Read latency: 0 cycles, combinational from the address inputs and register state.
- Write latency: 1 edge. Data written at edge N is visible on the read ports after edge N.
- Reset assertion: asynchronous. Outputs reach 0 within combinational delay of reset_n falling.
- Reset deassertion: reset_n is deasserted synchronously to clk by the top-level reset synchroniser. The first write is accepted on the first rising edge with reset_n=1.
- Output reset values: rd1=0, rd2=0, dbg_rd=0.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rd1 returns wd combinationally when we=1, reset_n=1, wa!=0 and ra1==wa. rd2 applies the same rule against ra2.
  - The new value is therefore visible in the same cycle as the write (write-through).
  - dbg_rd is not bypassed.
- Not defined:
  - Reads of wa during a write cycle return the old stored value.
  - The new value appears only after the write edge.
- In both builds, address 0 is never bypassed and always reads 0.

## Test plan
- Reset check: hold reset_n=0 and sweep ra1, ra2 and dbg_ra over 0..31 -> rd1, rd2 and dbg_rd are 0x00000000 for every address.
- Write/read: write 0xDEADBEEF to register 8 with we=1; on the next cycle set ra1=8 and ra2=8 -> both ports return 0xDEADBEEF, and dbg_ra=8 also returns 0xDEADBEEF.
- Zero register: write 0x12345678 to wa=0 with we=1; then set ra1=0 -> rd1=0x00000000 in both builds, including during the write cycle.
- Write disable and same-cycle read:
  - Store 0xAAAA5555 in register 9.
  - Present wd=0x0F0F0F0F, wa=9, we=0 and check ra1=9 after the edge -> rd1 is still 0xAAAA5555.
  - Repeat with we=1, checking ra1=9 before the edge -> rd1=0x0F0F0F0F with REGFILE_BYPASS_EN defined, 0xAAAA5555 without it.
- Reset mid-operation:
  - Write 0xCAFEF00D to register 31, then pull reset_n low between clock edges -> rd1 for ra1=31 drops to 0 before the next edge.
  - Release reset_n and write 0x1 to register 31 -> the read after the next edge returns 0x00000001.
